// File: rtl/shot_clock_counter_pkg.sv
// Shared types and constants for the shot-clock timing core.
package shot_clock_pkg;

  localparam int unsigned COUNT_W       = 5;
  localparam int unsigned FULL_VAL_DEF  = 24;
  localparam int unsigned SHORT_VAL_DEF = 14;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    EXPIRED = 2'd2
  } state_t;

endpackage

// File: rtl/shot_clock_counter_if.sv
// Control pulses in, shot-clock value and status out (count feeds the 7-seg decoder).
interface shot_clock_if;
  import shot_clock_pkg::*;

  logic               start_stop;
  logic               reload_full;
  logic               reload_short;
  logic [COUNT_W-1:0] count;
  logic               running;
  logic               expired;
  logic               buzzer;

  modport master (
    output start_stop, reload_full, reload_short,
    input  count, running, expired, buzzer
  );

  modport slave (
    input  start_stop, reload_full, reload_short,
    output count, running, expired, buzzer
  );

endinterface

// File: rtl/shot_clock_counter_tick_divider.sv
// Prescaler producing a one-cycle tick every TICK_DIV enabled cycles; holds when disabled.
module tick_divider #(
  parameter int unsigned TICK_DIV = 50_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int unsigned PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(TICK_DIV - 1);

  logic [PRE_W-1:0] pre;

  assign tick = en && (pre == PRE_MAX);

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      pre <= '0;
    end else if (en) begin
      if (pre == PRE_MAX) pre <= '0;
      else                pre <= pre + PRE_W'(1);
    end
  end

endmodule

// File: rtl/shot_clock_counter.sv
// Shot-clock core: reloadable 1 Hz down-counter with run/stop control and timed expiry buzzer.
module shot_clock_counter
  import shot_clock_pkg::*;
#(
  parameter int unsigned TICK_DIV    = 50_000_000,
  parameter int unsigned FULL_VAL    = FULL_VAL_DEF,
  parameter int unsigned SHORT_VAL   = SHORT_VAL_DEF,
  parameter int unsigned BUZZ_CYCLES = 100_000_000
) (
  input  logic         clk,
  input  logic         reset,
  shot_clock_if.slave  bus
);

  localparam int unsigned BUZZ_W = $clog2(BUZZ_CYCLES + 1);
  localparam logic [1:0]  S_IDLE    = 2'(IDLE);
  localparam logic [1:0]  S_RUN     = 2'(RUN);
  localparam logic [1:0]  S_EXPIRED = 2'(EXPIRED);
  localparam logic [COUNT_W-1:0] FULL_CNT  = COUNT_W'(FULL_VAL);
  localparam logic [COUNT_W-1:0] SHORT_CNT = COUNT_W'(SHORT_VAL);

  logic [1:0]         state, state_next;
  logic [COUNT_W-1:0] count_q, count_next;
  logic               running_q, expired_q, buzzer_q;
  logic [BUZZ_W-1:0]  buzz_cnt;
  logic               tick, reload, expiring;

  assign reload   = bus.reload_full | bus.reload_short;
  assign expiring = !reload && tick && (count_q == COUNT_W'(1));

  assign bus.count   = count_q;
  assign bus.running = running_q;
  assign bus.expired = expired_q;
  assign bus.buzzer  = buzzer_q;

  tick_divider #(.TICK_DIV(TICK_DIV)) u_tick_divider (
    .clk   (clk),
    .reset (reset),
    .en    (running_q),
    .clr   (reload | expired_q),
    .tick  (tick)
  );

  // Reload/tick resolved first; start_stop then acts on the resulting state.
  always_comb begin
    state_next = state;
    count_next = count_q;
    if (reload) begin
      count_next = bus.reload_full ? FULL_CNT : SHORT_CNT;
      if (state == S_EXPIRED) state_next = S_IDLE;
    end else if (tick) begin
      if (count_q == COUNT_W'(1)) begin
        count_next = '0;
        state_next = S_EXPIRED;
      end else if (count_q != '0) begin
        count_next = count_q - COUNT_W'(1);
      end
    end
    if (bus.start_stop) begin
      if (state_next == S_IDLE && count_next != '0) state_next = S_RUN;
      else if (state_next == S_RUN)                 state_next = S_IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      count_q   <= FULL_CNT;
      running_q <= 1'b0;
      expired_q <= 1'b0;
      buzzer_q  <= 1'b0;
      buzz_cnt  <= '0;
    end else begin
      state     <= state_next;
      count_q   <= count_next;
      running_q <= (state_next == S_RUN);
      expired_q <= (state_next == S_EXPIRED);
      // Buzzer is high for BUZZ_CYCLES edges counted from the expiry edge.
      if (reload) begin
        buzzer_q <= 1'b0;
        buzz_cnt <= '0;
      end else if (expiring) begin
        buzzer_q <= 1'b1;
        buzz_cnt <= BUZZ_W'(BUZZ_CYCLES);
      end else if (buzzer_q) begin
        buzzer_q <= (buzz_cnt != BUZZ_W'(1));
        buzz_cnt <= buzz_cnt - BUZZ_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_shot_clock_counter.sv
// Directed bench for shot_clock_counter with TICK_DIV=4 and BUZZ_CYCLES=6.
module tb_shot_clock_counter;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  shot_clock_if bus();

  shot_clock_counter #(
    .TICK_DIV    (4),
    .FULL_VAL    (24),
    .SHORT_VAL   (14),
    .BUZZ_CYCLES (6)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic status(input string tag, input int c, input int r, input int e, input int b);
    chk({tag, ".count"},   int'(bus.count),   c);
    chk({tag, ".running"}, int'(bus.running), r);
    chk({tag, ".expired"}, int'(bus.expired), e);
    chk({tag, ".buzzer"},  int'(bus.buzzer),  b);
  endtask

  // Advance n active edges; sample 1 time unit after the last one.
  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Apply inputs for exactly one active edge.
  task automatic pulse(input logic ss, input logic rf, input logic rs);
    bus.start_stop   = ss;
    bus.reload_full  = rf;
    bus.reload_short = rs;
    cyc(1);
    bus.start_stop   = 1'b0;
    bus.reload_full  = 1'b0;
    bus.reload_short = 1'b0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    bus.start_stop   = 1'b0;
    bus.reload_full  = 1'b0;
    bus.reload_short = 1'b0;
    reset = 1'b1;
    cyc(2);
    reset = 1'b0;
    status("reset", 24, 0, 0, 0);
    cyc(20);
    status("idle_hold", 24, 0, 0, 0);

    // Run: decrements at +4, +8, +12 after the start edge.
    pulse(1'b1, 1'b0, 1'b0);
    status("start", 24, 1, 0, 0);
    cyc(3);
    chk("pre_first_dec", int'(bus.count), 24);
    cyc(1);
    chk("dec_at_4", int'(bus.count), 23);
    cyc(4);
    chk("dec_at_8", int'(bus.count), 22);
    cyc(4);
    chk("dec_at_12", int'(bus.count), 21);

    // Pause 2 cycles after a decrement; remaining fraction is kept.
    cyc(1);
    pulse(1'b1, 1'b0, 1'b0);
    status("paused", 21, 0, 0, 0);
    cyc(10);
    status("paused_hold", 21, 0, 0, 0);
    pulse(1'b1, 1'b0, 1'b0);
    status("restart", 21, 1, 0, 0);
    cyc(1);
    chk("restart_plus1", int'(bus.count), 21);
    cyc(1);
    chk("restart_plus2", int'(bus.count), 20);

    // Reload_short while running at 7.
    cyc(52);
    chk("at_seven", int'(bus.count), 7);
    cyc(1);
    pulse(1'b0, 1'b0, 1'b1);
    status("reload_run", 14, 1, 0, 0);
    cyc(3);
    chk("reload_run_plus3", int'(bus.count), 14);
    cyc(1);
    chk("reload_run_plus4", int'(bus.count), 13);

    // From reload_short to expiry: 14 * 4 = 56 cycles.
    reset = 1'b1;
    cyc(1);
    reset = 1'b0;
    status("reset2", 24, 0, 0, 0);
    pulse(1'b0, 1'b0, 1'b1);
    status("short_idle", 14, 0, 0, 0);
    pulse(1'b1, 1'b0, 1'b0);
    cyc(55);
    status("before_zero", 1, 1, 0, 0);
    cyc(1);
    status("expiry", 0, 0, 1, 1);
    cyc(5);
    chk("buzz_cycle6", int'(bus.buzzer), 1);
    cyc(1);
    status("buzz_off", 0, 0, 1, 0);
    pulse(1'b1, 1'b0, 1'b0);
    status("ss_ignored", 0, 0, 1, 0);
    cyc(3);
    status("expired_hold", 0, 0, 1, 0);

    // Reload_short with start_stop from EXPIRED runs with the new value.
    pulse(1'b1, 1'b0, 1'b1);
    status("reload_start", 14, 1, 0, 0);
    cyc(4);
    chk("reload_start_dec", int'(bus.count), 13);
    cyc(52);
    status("expiry2", 0, 0, 1, 1);
    cyc(2);
    chk("buzz_mid", int'(bus.buzzer), 1);

    // Both reloads together while buzzing: full wins, back to IDLE, buzzer off.
    pulse(1'b0, 1'b1, 1'b1);
    status("dual_reload", 24, 0, 0, 0);
    cyc(8);
    status("dual_reload_hold", 24, 0, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
